seven_seg_scan_driver: RTL
==========================

Name: seven_seg_scan_driver

Overview:
- Output stage directly downstream of the ALU's BCD converter.
- Captures the hundreds/tens/ones BCD digits plus the carry and overflow flags on a load strobe.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display, with leading-zero blanking, invalid-code indication and an inter-digit anti-ghosting blank.
- Digit 3, the leftmost, shows 'C' when the latched carry is set.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; minimum 4.
- BLANK_CYCLES, 2: cycles at the start of each slot during which all anodes are off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1: 1 = seg and dp are driven active-low.
- AN_ACTIVE_LOW, 1: 1 = an is driven active-low.
- BLANK_LEADING, 1: 1 = enable leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; latches all digit and flag inputs.
- h  in  4  hundreds BCD digit (h3..h0).
- t  in  4  tens BCD digit.
- o  in  4  ones BCD digit.
- carry_in_flag  in  1  ALU carry_out_output.
- ovf_in_flag  in  1  ALU overflow.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  4  anode enables; an[0] = ones … an[3] = flag digit.

Behaviour:
- Reset and clocking:
  - One clock, clk. rst is asynchronous and active-high.
  - Asserting rst at any time, including mid-slot, immediately clears: prescaler = 0, digit index = 0, latched h/t/o = 0, latched flags = 0.
  - While in reset, all outputs are registered inactive: an all off, seg all off, dp off. Physical levels follow the polarity parameters.
- Input latch:
  - load=1 at edge N: h, t, o and both flags are captured at edge N.
  - load=0: latched values hold.
  - load is ignored during reset.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At the wrap, the digit index advances 0→1→2→3→0.
- Anti-ghost blank:
  - While prescaler < BLANK_CYCLES, an is all off.
  - Otherwise exactly one an bit, the one for the current index, is on.
- Output registers:
  - seg, dp and an are registered. They reflect the index and latched data of the previous cycle, so output latency is 1 clock from the internal state.
  - A load at edge N is visible on seg at edge N+1 if that digit is the one being driven.
- Digit content:
  - Index 0: o, never blanked.
  - Index 1: t; blanked when BLANK_LEADING=1, h==0 and t==0.
  - Index 2: h; blanked when BLANK_LEADING=1 and h==0.
  - Index 3: 'C' when the carry flag is latched, otherwise blank.
  - dp is on only at index 0 when the overflow flag is latched.
- Invalid BCD: any digit value > 9 displays 'E' and counts as nonzero for blanking decisions.
- Segment encoding (active-high, {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - E=1111001, C=0111001, blank=0000000
  - When SEG_ACTIVE_LOW=1, seg and dp are bitwise inverted; when AN_ACTIVE_LOW=1, an is bitwise inverted.
- Simultaneous events:
  - load coinciding with a prescaler wrap: the new data and the new index both take effect together, so the next cycle shows the new data on the new digit.
  - rst dominates all other events.
- Blanked slots: a blanked digit still occupies its full slot with an asserted and seg at blank, so scan timing is uniform.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_E, SEG_C, SEG_BLANK;
  - digit index typedef (2-bit);
  - an one-hot constants AN_DIG0..AN_DIG3.
- Sub-module bcd_to_seg7: purely combinational; 4-bit code plus blank input → 7-bit active-high pattern; > 9 → SEG_E.
- Top module: prescaler, index counter, input latch, blanking logic, output registers and polarity inversion.

Test Plan (bench uses REFRESH_DIV=4, BLANK_CYCLES=1, active-low both):
- Reset check: assert rst mid-slot for 3 cycles → an=1111, seg=1111111, dp=1 immediately; after release, the first anode is an=1110 at prescaler=1.
- Load h=1, t=2, o=3, flags 0 → over 16 cycles each slot shows one blank cycle, then: ones seg=0110000 (~3), tens seg=0100100 (~2), hundreds seg=1111001 (~1), flag digit blank seg=1111111.
- Load h=0, t=0, o=5 → tens and hundreds slots show seg=1111111 with an still asserted; ones shows seg=0010010 (~5). Repeat with BLANK_LEADING=0 → both show ~0=1000000.
- Load h=0, t=0xA, o=0 → tens shows ~E=0000110 and hundreds is blank.
- Load with carry=1, ovf=1 → flag slot shows ~C=1000110; dp=0 only during the ones slot.
- Pulse load on the wrap cycle with new data → next cycle's digit shows the new value; assert rst during an active slot → outputs go inactive within the same cycle (asynchronous).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Contents:
//   SEG_*       active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   digit_idx_t 2-bit scan position (0 = ones ... 3 = flag digit)
//   AN_*        active-high one-hot anode patterns per scan position
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] AN_DIG0 = 4'b0001;
    localparam logic [3:0] AN_DIG1 = 4'b0010;
    localparam logic [3:0] AN_DIG2 = 4'b0100;
    localparam logic [3:0] AN_DIG3 = 4'b1000;
    localparam logic [3:0] AN_NONE = 4'b0000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (active-high pattern).
// Ports:
//   code    in  4  BCD digit; values above 9 render as 'E'
//   blank   in  1  force an all-off pattern
//   pattern out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_E;
        if (blank) begin
            pattern = SEG_BLANK;
        end else begin
            case (code)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver for the BCD result of the ALU.
// Latches hundreds/tens/ones plus carry/overflow on load and scans them
// onto a common-anode display with leading-zero blanking, an 'E' for
// invalid codes, a 'C' carry indicator and a short anti-ghost blank at
// the start of every digit slot.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              single-cycle capture strobe for h/t/o and flags
//   h, t, o           BCD digits (hundreds, tens, ones)
//   carry_in_flag     shown as 'C' on the leftmost digit
//   ovf_in_flag       lights dp on the ones digit
//   seg, dp, an       registered display outputs at physical polarity
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] h,
    input  logic [3:0] t,
    input  logic [3:0] o,
    input  logic       carry_in_flag,
    input  logic       ovf_in_flag,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);

    // XOR masks turning active-high internal values into physical levels;
    // the inactive physical level is simply the mask itself.
    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? 4'hf : 4'h0;

    logic [PW-1:0] presc_reg;
    digit_idx_t    idx_reg;
    logic [3:0]    h_reg, t_reg, o_reg;
    logic          carry_reg, ovf_reg;

    logic [6:0] seg_reg, seg_next;
    logic       dp_reg, dp_next;
    logic [3:0] an_reg, an_next;

    logic [3:0] code_sel;
    logic       blank_sel;
    logic [6:0] dec_pattern;

    // Scan timing: prescaler wrap advances the digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (presc_reg == PRESC_MAX) begin
            presc_reg <= '0;
            idx_reg   <= idx_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Input latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg     <= '0;
            t_reg     <= '0;
            o_reg     <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (load) begin
            h_reg     <= h;
            t_reg     <= t;
            o_reg     <= o;
            carry_reg <= carry_in_flag;
            ovf_reg   <= ovf_in_flag;
        end
    end

    // Digit selection and leading-zero blanking. Only a literal zero
    // counts as zero, so an invalid hundreds code keeps tens visible.
    always_comb begin
        code_sel  = o_reg;
        blank_sel = 1'b0;
        case (idx_reg)
            2'd0: begin
                code_sel  = o_reg;
                blank_sel = 1'b0;
            end
            2'd1: begin
                code_sel  = t_reg;
                blank_sel = (BLANK_LEADING != 0) && (h_reg == 4'd0) && (t_reg == 4'd0);
            end
            2'd2: begin
                code_sel  = h_reg;
                blank_sel = (BLANK_LEADING != 0) && (h_reg == 4'd0);
            end
            default: begin
                code_sel  = 4'd0;
                blank_sel = 1'b1;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .code    (code_sel),
        .blank   (blank_sel),
        .pattern (dec_pattern)
    );

    always_comb begin
        seg_next = dec_pattern;
        if (idx_reg == 2'd3) begin
            seg_next = carry_reg ? SEG_C : SEG_BLANK;
        end

        dp_next = (idx_reg == 2'd0) && ovf_reg;

        case (idx_reg)
            2'd0:    an_next = AN_DIG0;
            2'd1:    an_next = AN_DIG1;
            2'd2:    an_next = AN_DIG2;
            default: an_next = AN_DIG3;
        endcase
        // Anti-ghost: anodes stay off while segments settle to the new digit.
        if (presc_reg < BLANK_LIM) begin
            an_next = AN_NONE;
        end
    end

    // Output flops hold physical levels so the pins come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg <= SEG_INV;
            dp_reg  <= DP_INV;
            an_reg  <= AN_INV;
        end else begin
            seg_reg <= seg_next ^ SEG_INV;
            dp_reg  <= dp_next ^ DP_INV;
            an_reg  <= an_next ^ AN_INV;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule
